// File: rtl/serial_link_train_ctrl.sv
// Per-lane receive-delay training sequencer: sweeps every tap, scores a toggle pattern
// and centres each lane in its longest passing window. Optional watchdog: SERIAL_LINK_TRAIN_TIMEOUT_EN.
module serial_link_train_ctrl #(
    parameter int NumLanes     = 8,
    parameter int DelayW       = 5,
    parameter int SettleCycles = 16,
    parameter int CheckCycles  = 64
`ifdef SERIAL_LINK_TRAIN_TIMEOUT_EN
    ,
    parameter int TimeoutCycles = 1024
`endif
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [NumLanes-1:0]          train_mask_i,
    input  logic [NumLanes-1:0]          rx_data_i,
    input  logic                         rx_valid_i,
    output logic                         tx_train_o,
    output logic [NumLanes*DelayW-1:0]   delay_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [NumLanes-1:0]          fail_o
);

    localparam int LenW   = DelayW + 1;
    localparam int CntMax = (SettleCycles > CheckCycles) ? SettleCycles : CheckCycles;
    localparam int CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0]   SettleLast = CntW'(SettleCycles - 1);
    localparam logic [CntW-1:0]   CheckLast  = CntW'(CheckCycles - 1);
    localparam logic [DelayW-1:0] TapLast    = {DelayW{1'b1}};
`ifdef SERIAL_LINK_TRAIN_TIMEOUT_EN
    localparam int WdW = $clog2(TimeoutCycles + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TimeoutCycles - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_RECORD,
        ST_CENTER,
        ST_DONE
    } state_e;

    state_e                             state_q, state_d;
    logic [DelayW-1:0]                  tap_q, tap_d;
    logic [CntW-1:0]                    cnt_q, cnt_d;
    logic [NumLanes-1:0]                mask_q, mask_d;
    logic [NumLanes-1:0]                prev_q, prev_d;
    logic                               prev_valid_q, prev_valid_d;
    logic [NumLanes-1:0]                err_q, err_d;
    logic [NumLanes-1:0]                fail_q, fail_d;
    logic [NumLanes-1:0][DelayW-1:0]    delay_q, delay_d;
    logic [NumLanes-1:0][DelayW-1:0]    cur_start_q, cur_start_d;
    logic [NumLanes-1:0][LenW-1:0]      cur_len_q, cur_len_d;
    logic [NumLanes-1:0][DelayW-1:0]    best_start_q, best_start_d;
    logic [NumLanes-1:0][LenW-1:0]      best_len_q, best_len_d;
`ifdef SERIAL_LINK_TRAIN_TIMEOUT_EN
    logic [WdW-1:0]                     wd_q, wd_d;
`endif

    // Window centre, floor; len[DelayW:1] is len>>1 and cannot exceed 2**(DelayW-1).
    function automatic logic [DelayW-1:0] center_tap(input logic [DelayW-1:0] start,
                                                     input logic [LenW-1:0]   len);
        return start + len[DelayW:1];
    endfunction

    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        cnt_d        = cnt_q;
        mask_d       = mask_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        err_d        = err_q;
        fail_d       = fail_q;
        delay_d      = delay_q;
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
`ifdef SERIAL_LINK_TRAIN_TIMEOUT_EN
        wd_d         = wd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mask_d       = train_mask_i;
                    tap_d        = '0;
                    cnt_d        = '0;
                    fail_d       = '0;
                    cur_start_d  = '0;
                    cur_len_d    = '0;
                    best_start_d = '0;
                    best_len_d   = '0;
                    for (int n = 0; n < NumLanes; n++) begin
                        if (train_mask_i[n]) delay_d[n] = '0;
                    end
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SettleLast) begin
                    cnt_d        = '0;
                    err_d        = '0;
                    prev_valid_d = 1'b0;
`ifdef SERIAL_LINK_TRAIN_TIMEOUT_EN
                    wd_d         = '0;
`endif
                    state_d      = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_CHECK: begin
`ifdef SERIAL_LINK_TRAIN_TIMEOUT_EN
                wd_d = wd_q + WdW'(1);
`endif
                if (rx_valid_i) begin
                    prev_d = rx_data_i;
                    // The first sample only seeds prev; it is not counted.
                    if (!prev_valid_q) begin
                        prev_valid_d = 1'b1;
                    end else begin
                        err_d = err_q | ~(rx_data_i ^ prev_q);
                        if (cnt_q == CheckLast) state_d = ST_RECORD;
                        else                    cnt_d   = cnt_q + CntW'(1);
                    end
                end
`ifdef SERIAL_LINK_TRAIN_TIMEOUT_EN
                if (state_d == ST_CHECK && wd_q == WdLast) begin
                    for (int n = 0; n < NumLanes; n++) begin
                        if (mask_q[n]) begin
                            fail_d[n]  = 1'b1;
                            delay_d[n] = '0;
                        end
                    end
                    state_d = ST_DONE;
                end
`endif
            end
            ST_RECORD: begin
                for (int n = 0; n < NumLanes; n++) begin
                    if (mask_q[n]) begin
                        if (!err_q[n]) begin
                            if (cur_len_q[n] == '0) cur_start_d[n] = tap_q;
                            cur_len_d[n] = cur_len_q[n] + LenW'(1);
                            // Strictly longer only, so the earliest window keeps a tie.
                            if (cur_len_d[n] > best_len_q[n]) begin
                                best_start_d[n] = cur_start_d[n];
                                best_len_d[n]   = cur_len_d[n];
                            end
                        end else begin
                            cur_len_d[n] = '0;
                        end
                    end
                end
                if (tap_q == TapLast) begin
                    state_d = ST_CENTER;
                end else begin
                    tap_d = tap_q + DelayW'(1);
                    cnt_d = '0;
                    for (int n = 0; n < NumLanes; n++) begin
                        if (mask_q[n]) delay_d[n] = tap_d;
                    end
                    state_d = ST_SETTLE;
                end
            end
            ST_CENTER: begin
                for (int n = 0; n < NumLanes; n++) begin
                    if (mask_q[n]) begin
                        if (best_len_q[n] == '0) begin
                            delay_d[n] = '0;
                            fail_d[n]  = 1'b1;
                        end else begin
                            delay_d[n] = center_tap(best_start_q[n], best_len_q[n]);
                        end
                    end
                end
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            tap_q        <= '0;
            cnt_q        <= '0;
            mask_q       <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            err_q        <= '0;
            fail_q       <= '0;
            delay_q      <= '0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
`ifdef SERIAL_LINK_TRAIN_TIMEOUT_EN
            wd_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            err_q        <= err_d;
            fail_q       <= fail_d;
            delay_q      <= delay_d;
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
`ifdef SERIAL_LINK_TRAIN_TIMEOUT_EN
            wd_q         <= wd_d;
`endif
        end
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign tx_train_o = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign delay_o    = delay_q;
    assign fail_o     = fail_q;

endmodule
